one_bit_comparator: RTL and testbench

//   Registered magnitude/equality comparator for two single-bit operands a, b.

---
 rtl/one_bit_comparator.sv | 56 +++++
 tb/tb_one_bit_comparator.sv | 133 +++++++++++++
 2 files changed

// File: rtl/one_bit_comparator.sv
// Registered unsigned comparator: equal / not-equal / greater / less flags
// for operands a and b, one-cycle latency, cleared asynchronously by rst.
module one_bit_comparator #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f
);

    logic eq_d, ne_d, gt_d, lt_d;
    logic eq_q, ne_q, gt_q, lt_q;

    // Next-state flags; exactly one of eq/gt/lt is set, and ne covers gt|lt.
    always_comb begin
        eq_d = 1'b0;
        ne_d = 1'b0;
        gt_d = 1'b0;
        lt_d = 1'b0;
        if (a == b) begin
            eq_d = 1'b1;
        end else if (a > b) begin
            ne_d = 1'b1;
            gt_d = 1'b1;
        end else begin
            ne_d = 1'b1;
            lt_d = 1'b1;
        end
    end

    // Flag registers; rst discards any in-flight result immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q <= 1'b0;
            ne_q <= 1'b0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
            ne_q <= ne_d;
            gt_q <= gt_d;
            lt_q <= lt_d;
        end
    end

    assign c = eq_q;
    assign d = ne_q;
    assign e = gt_q;
    assign f = lt_q;

endmodule

// File: tb/tb_one_bit_comparator.sv
// Self-checking bench for one_bit_comparator: reset behaviour, truth-table
// vectors, mid-cycle input changes, async reset, and random vs. a reference model.
module tb_one_bit_comparator;

    localparam int WIDTH = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] a   = '0;
    logic [WIDTH-1:0] b   = '0;
    logic             c, d, e, f;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       exp;   // {c,d,e,f}
    } vec_t;

    vec_t vecs [4];

    one_bit_comparator #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e),
        .f   (f)
    );

    always #5 clk = ~clk;

    // Reference: sign of the arithmetic difference decides every flag.
    function automatic logic [3:0] ref_flags(input int unsigned ra, input int unsigned rb);
        longint diff;
        logic eq, gt, lt;
        diff = longint'(ra) - longint'(rb);
        eq   = (diff == 0);
        gt   = (diff > 0);
        lt   = (diff < 0);
        return {eq, !eq, gt, lt};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cdef=%b expected cdef=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inv(input string name);
        checks++;
        if (((c ^ d) !== 1'b1) || ((e & f) !== 1'b0) || (d !== (e | f))) begin
            errors++;
            $display("FAIL %s: invariant broken cdef=%b%b%b%b at %0t", name, c, d, e, f, $time);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] prev_a, prev_b;

        vecs[0] = '{a: 1'b0, b: 1'b0, exp: 4'b1000};
        vecs[1] = '{a: 1'b0, b: 1'b1, exp: 4'b0101};
        vecs[2] = '{a: 1'b1, b: 1'b0, exp: 4'b0110};
        vecs[3] = '{a: 1'b1, b: 1'b1, exp: 4'b1000};

        // 1: reset held with a=1,b=0, checked before the first edge and while clocking
        a = 1'b1;
        b = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_before_edge", {c, d, e, f}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_held", {c, d, e, f}, 4'b0000);
        end

        // 2: release, then truth table, each pair held two cycles
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                check($sformatf("table_%0d_cyc%0d", i, k), {c, d, e, f}, vecs[i].exp);
            end
        end

        // 3: mid-cycle change must not show until the next rising edge
        a = 1'b0;
        b = 1'b0;
        @(negedge clk);
        check("midcycle_before", {c, d, e, f}, 4'b1000);
        #2 a = 1'b1;
        #1 check("midcycle_hold", {c, d, e, f}, 4'b1000);
        @(negedge clk);
        check("midcycle_after", {c, d, e, f}, 4'b0110);

        // 4: asynchronous reset mid-cycle, then recovery on the next edge
        @(negedge clk);
        check("async_pre", {c, d, e, f}, 4'b0110);
        #1 rst = 1'b1;
        #1 check("async_clear", {c, d, e, f}, 4'b0000);
        @(negedge clk);
        check("async_held", {c, d, e, f}, 4'b0000);
        rst = 1'b0;
        #1 check("async_release_noedge", {c, d, e, f}, 4'b0000);
        @(negedge clk);
        check("async_recover", {c, d, e, f}, 4'b0110);

        // 5: random operands against the reference model plus invariants
        prev_a = a;
        prev_b = b;
        for (int n = 0; n < 1000; n++) begin
            a = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            b = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            #1 check("random_hold", {c, d, e, f}, ref_flags(prev_a, prev_b));
            @(negedge clk);
            check("random", {c, d, e, f}, ref_flags(a, b));
            check_inv("random_inv");
            prev_a = a;
            prev_b = b;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
